// File: rtl/matrix_stream_generator.sv
`default_nettype none
// ============================================================================
// Module   : matrix_stream_generator
// Purpose  : Emits NUM_MATRICES row-major ROWS x COLS matrices on an
//            AXI-Stream master port, each preceded by GAP_CYCLES idle cycles.
//            Patterns: 0 increment, 1 identity, 2 constant, 3 LFSR.
// Options  : define MATGEN_LFSR_EN to build the Galois LFSR used by mode 3;
//            without it mode 3 falls back to the increment pattern.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_stream_generator #(
    parameter int DATA_W       = 32,
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int NUM_MATRICES = 2,
    parameter int GAP_CYCLES   = 20000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] input_r_TDATA_0,
    output logic              input_r_TVALID_0,
    output logic              input_r_TLAST_0,
    input  logic              input_r_TREADY_0,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GAP    = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0]        ROW_LAST = 8'(ROWS - 1);
    localparam logic [7:0]        COL_LAST = 8'(COLS - 1);
    localparam logic [3:0]        MAT_LAST = 4'(NUM_MATRICES - 1);
    // A zero-length gap still spends one cycle in GAP, same as a length of one.
    localparam logic [19:0]       GAP_LAST = 20'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

    state_t            state, state_n;
    logic [19:0]       gap_cnt, gap_n;
    logic [3:0]        m_idx, m_n;
    logic [7:0]        r_idx, r_n, c_idx, c_n;
    logic [DATA_W-1:0] inc_val, inc_n;     // seed + linear element index
    logic [1:0]        mode_q, mode_n;
    logic [DATA_W-1:0] seed_q, seed_n;
    logic [DATA_W-1:0] pat;

`ifdef MATGEN_LFSR_EN
    // Right-shifting Galois feedback masks; maximal-length for the common widths.
    function automatic logic [DATA_W-1:0] lfsr_taps();
        case (DATA_W)
            8:       return DATA_W'(64'h0000_0000_0000_00B8);
            16:      return DATA_W'(64'h0000_0000_0000_B400);
            32:      return DATA_W'(64'h0000_0000_8020_0003);
            64:      return DATA_W'(64'hD800_0000_0000_0000);
            default: return {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
        endcase
    endfunction
    localparam logic [DATA_W-1:0] LFSR_TAPS = lfsr_taps();

    logic [DATA_W-1:0] lfsr, lfsr_n;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and next-counter logic; TVALID is high exactly in STREAM.
    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        m_n     = m_idx;
        r_n     = r_idx;
        c_n     = c_idx;
        inc_n   = inc_val;
        mode_n  = mode_q;
        seed_n  = seed_q;
`ifdef MATGEN_LFSR_EN
        lfsr_n  = lfsr;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = GAP;
                    gap_n   = '0;
                    m_n     = '0;
                    r_n     = '0;
                    c_n     = '0;
                    mode_n  = mode;
                    seed_n  = seed;
                    inc_n   = seed;
`ifdef MATGEN_LFSR_EN
                    lfsr_n  = (seed == '0) ? ONE : seed;
`endif
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_n = STREAM;
                else                     gap_n   = gap_cnt + 20'd1;
            end
            STREAM: begin
                if (input_r_TREADY_0) begin
                    inc_n = inc_val + ONE;
`ifdef MATGEN_LFSR_EN
                    lfsr_n = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
`endif
                    if (c_idx == COL_LAST) begin
                        c_n = '0;
                        if (r_idx == ROW_LAST) begin
                            r_n = '0;
                            if (m_idx == MAT_LAST) begin
                                state_n = DONE;
                            end else begin
                                m_n     = m_idx + 4'd1;
                                gap_n   = '0;
                                state_n = GAP;
                            end
                        end else begin
                            r_n = r_idx + 8'd1;
                        end
                    end else begin
                        c_n = c_idx + 8'd1;
                    end
                end
            end
            default: state_n = IDLE;   // DONE lasts a single cycle
        endcase
    end

    // Pattern value of the element the stream will present next.
    always_comb begin
        pat = inc_n;
        case (mode_n)
            2'd1: pat = DATA_W'(r_n == c_n);
            2'd2: pat = seed_n;
`ifdef MATGEN_LFSR_EN
            2'd3: pat = lfsr_n;
`else
            2'd3: pat = inc_n;
`endif
            default: pat = inc_n;
        endcase
    end

    // Counter, latched-configuration and LFSR registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
            m_idx   <= '0;
            r_idx   <= '0;
            c_idx   <= '0;
            inc_val <= '0;
            mode_q  <= '0;
            seed_q  <= '0;
`ifdef MATGEN_LFSR_EN
            lfsr    <= '0;
`endif
        end else begin
            gap_cnt <= gap_n;
            m_idx   <= m_n;
            r_idx   <= r_n;
            c_idx   <= c_n;
            inc_val <= inc_n;
            mode_q  <= mode_n;
            seed_q  <= seed_n;
`ifdef MATGEN_LFSR_EN
            lfsr    <= lfsr_n;
`endif
        end
    end

    // Registered outputs, derived from the upcoming state so they align with it;
    // during a stall the indices do not move, so TDATA/TLAST hold naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            input_r_TDATA_0  <= '0;
            input_r_TVALID_0 <= 1'b0;
            input_r_TLAST_0  <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            input_r_TDATA_0  <= (state_n == STREAM) ? pat : '0;
            input_r_TVALID_0 <= (state_n == STREAM);
            input_r_TLAST_0  <= (state_n == STREAM) && (r_n == ROW_LAST) && (c_n == COL_LAST);
            busy             <= (state_n != IDLE);
            done             <= (state_n == DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_stream_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_stream_generator
// Purpose  : Self-checking bench for matrix_stream_generator using three
//            parameterisations: defaults, a 3x3 single-matrix zero-gap build,
//            and a small 8-bit build driven with random stimulus and checked
//            against a behavioural model. Honours MATGEN_LFSR_EN for mode 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_stream_generator;

    localparam int R2 = 3, C2 = 5, N2 = 3, G2 = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // dut0: default parameters
    logic        s0_start, s0_ready;
    logic [1:0]  s0_mode;
    logic [31:0] s0_seed, d0_data;
    logic        d0_valid, d0_last, d0_busy, d0_done;
    // dut1: 3x3, one matrix, no gap
    logic        s1_start, s1_ready;
    logic [1:0]  s1_mode;
    logic [31:0] s1_seed, d1_data;
    logic        d1_valid, d1_last, d1_busy, d1_done;
    // dut2: 8-bit, 3x5, three matrices, gap 3
    logic        s2_start, s2_ready;
    logic [1:0]  s2_mode;
    logic [7:0]  s2_seed, d2_data;
    logic        d2_valid, d2_last, d2_busy, d2_done;

    matrix_stream_generator dut0 (
        .clk(clk), .reset(reset), .start(s0_start), .mode(s0_mode), .seed(s0_seed),
        .input_r_TDATA_0(d0_data), .input_r_TVALID_0(d0_valid), .input_r_TLAST_0(d0_last),
        .input_r_TREADY_0(s0_ready), .busy(d0_busy), .done(d0_done));

    matrix_stream_generator #(.DATA_W(32), .ROWS(3), .COLS(3), .NUM_MATRICES(1), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .start(s1_start), .mode(s1_mode), .seed(s1_seed),
        .input_r_TDATA_0(d1_data), .input_r_TVALID_0(d1_valid), .input_r_TLAST_0(d1_last),
        .input_r_TREADY_0(s1_ready), .busy(d1_busy), .done(d1_done));

    matrix_stream_generator #(.DATA_W(8), .ROWS(R2), .COLS(C2), .NUM_MATRICES(N2), .GAP_CYCLES(G2)) dut2 (
        .clk(clk), .reset(reset), .start(s2_start), .mode(s2_mode), .seed(s2_seed),
        .input_r_TDATA_0(d2_data), .input_r_TVALID_0(d2_valid), .input_r_TLAST_0(d2_last),
        .input_r_TREADY_0(s2_ready), .busy(d2_busy), .done(d2_done));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected beats of a dut2 run as {last, data}, built from the pattern rules.
    logic [8:0] exp_q[$];

    task automatic build_exp(input logic [1:0] md, input logic [7:0] sd);
        logic [7:0] v;
        int idx;
`ifdef MATGEN_LFSR_EN
        logic [7:0] lf;
        lf = (sd == 8'd0) ? 8'd1 : sd;
`endif
        exp_q.delete();
        for (int m = 0; m < N2; m++)
            for (int r = 0; r < R2; r++)
                for (int c = 0; c < C2; c++) begin
                    idx = m * R2 * C2 + r * C2 + c;
                    case (md)
                        2'd1: v = (r == c) ? 8'd1 : 8'd0;
                        2'd2: v = sd;
`ifdef MATGEN_LFSR_EN
                        2'd3: begin
                            v = lf;
                            // x^8+x^6+x^5+x^4+1, right-shifting Galois form
                            lf = lf[0] ? ((lf >> 1) ^ 8'hB8) : (lf >> 1);
                        end
`endif
                        default: v = 8'((int'(sd) + idx) % 256);
                    endcase
                    exp_q.push_back({(r == R2 - 1) && (c == C2 - 1), v});
                end
    endtask

    // One dut2 run. style 0: always ready, 1: random ready, 2: 10-cycle stall at beat 6.
    task automatic run2(input logic [1:0] md, input logic [7:0] sd, input int style);
        int cyc, gap, got, stall_cnt, total;
        bit prev_stall, fin, rdy;
        logic [7:0] prev_data;
        logic prev_last;
        logic [8:0] e;
        build_exp(md, sd);
        total = exp_q.size();
        cyc = 0; gap = 0; got = 0; stall_cnt = 0;
        prev_stall = 0; fin = 0; prev_data = '0; prev_last = 0;
        @(negedge clk); s2_mode = md; s2_seed = sd; s2_start = 1'b1;
        @(negedge clk); s2_start = 1'b0; s2_mode = 2'($urandom); s2_seed = 8'($urandom);
        while (!fin && cyc < 3000) begin
            if (d2_done) begin
                chk("r2_done_gap", gap, 0);
                chk("r2_beats", got, total);
                s2_start = 1'b0;
                fin = 1;
            end else if (!d2_valid) begin
                if (prev_stall) chk("r2_valid_hold", d2_valid, 1);
                prev_stall = 0;
                gap++;
                chk("r2_busy_gap", d2_busy, 1);
                s2_start = 1'($urandom_range(0, 1));
            end else begin
                if (gap != 0) begin
                    chk("r2_gap_len", gap, G2);
                    gap = 0;
                end
                if (prev_stall) begin
                    chk("r2_hold_data", d2_data, prev_data);
                    chk("r2_hold_last", d2_last, prev_last);
                end
                case (style)
                    0: rdy = 1;
                    1: rdy = ($urandom_range(0, 3) != 0);
                    default: begin
                        rdy = !(got == 6 && stall_cnt < 10);
                        if (!rdy) stall_cnt++;
                    end
                endcase
                s2_ready = rdy;
                if (rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("r2_extra_beat", got, total);
                    end else begin
                        e = exp_q.pop_front();
                        chk("r2_data", d2_data, e[7:0]);
                        chk("r2_last", d2_last, e[8]);
                    end
                    got++;
                end
                prev_stall = !rdy;
                prev_data  = d2_data;
                prev_last  = d2_last;
                s2_start = 1'($urandom_range(0, 1));
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("r2_finished", fin, 1);
        s2_start = 1'b0;
        if (fin) begin
            @(negedge clk);
            chk("r2_done_pulse", d2_done, 0);
            chk("r2_idle_busy", d2_busy, 0);
        end
    endtask

    typedef struct packed {
        logic [1:0]        mode;
        logic [31:0]       seed;
        logic [0:8][31:0]  exp;
    } vec_t;
    vec_t tbl [3];

    initial begin
        int k, cyc, gap;

        tbl[0].mode = 2'd1; tbl[0].seed = 32'h0000_1234;
        tbl[0].exp  = {32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1};
        tbl[1].mode = 2'd2; tbl[1].seed = 32'hDEAD_BEEF;
        tbl[1].exp  = {9{32'hDEAD_BEEF}};
        tbl[2].mode = 2'd0; tbl[2].seed = 32'hFFFF_FFFE;
        tbl[2].exp  = {32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};

        reset = 1'b1;
        s0_start = 0; s0_ready = 1; s0_mode = 2'd0; s0_seed = '0;
        s1_start = 0; s1_ready = 1; s1_mode = 2'd0; s1_seed = '0;
        s2_start = 0; s2_ready = 1; s2_mode = 2'd0; s2_seed = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", d2_valid, 0);
        chk("rst_busy", d2_busy, 0);
        chk("rst_done", d2_done, 0);
        chk("rst_data", d2_data, 0);
        chk("rst_busy0", d0_busy, 0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", d2_busy, 0);
            chk("idle_valid", d1_valid, 0);
        end

        // 3x3 table: identity, constant, increment with wrap
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); s1_mode = tbl[i].mode; s1_seed = tbl[i].seed; s1_start = 1'b1;
            @(negedge clk); s1_start = 1'b0; s1_seed = ~s1_seed;
            k = 0; cyc = 0; gap = 0;
            while (k < 9 && cyc < 50) begin
                if (d1_valid) begin
                    chk("t1_data", d1_data, tbl[i].exp[k]);
                    chk("t1_last", d1_last, k == 8);
                    k++;
                end else begin
                    gap++;
                end
                @(negedge clk);
                cyc++;
            end
            chk("t1_beats", k, 9);
            chk("t1_gap", gap, 1);
            chk("t1_done", d1_done, 1);
            @(negedge clk);
            chk("t1_done_end", d1_done, 0);
            chk("t1_busy_end", d1_busy, 0);
        end

        // dut2 directed and random runs
        run2(2'd0, 8'd250, 0);
        run2(2'd0, 8'd5, 2);
        run2(2'd3, 8'd0, 1);
        run2(2'd1, 8'd0, 0);
        run2(2'd2, 8'hA5, 1);
        for (int i = 0; i < 12; i++) run2(2'($urandom), 8'($urandom), 1);

        // asynchronous reset while stalled mid-stream
        @(negedge clk); s2_mode = 2'd0; s2_seed = 8'd9; s2_start = 1'b1; s2_ready = 1'b0;
        @(negedge clk); s2_start = 1'b0;
        cyc = 0;
        while (!d2_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rs_reach_stream", d2_valid, 1);
        chk("rs_stall_data", d2_data, 9);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rs_valid", d2_valid, 0);
        chk("rs_busy", d2_busy, 0);
        chk("rs_data", d2_data, 0);
        chk("rs_last", d2_last, 0);
        chk("rs_done", d2_done, 0);
        @(negedge clk); reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rs_stay_idle", d2_busy, 0);
        end
        run2(2'd0, 8'd9, 1);

        // default build: 20000-cycle gaps, beats 0..31
        @(negedge clk); s0_start = 1'b1;
        @(negedge clk); s0_start = 1'b0;
        k = 0; gap = 0; cyc = 0;
        while (!d0_done && cyc < 45000) begin
            if (!d0_valid) begin
                gap++;
            end else begin
                if (gap != 0) begin
                    chk("d0_gap", gap, 20000);
                    gap = 0;
                end
                chk("d0_data", d0_data, k);
                chk("d0_last", d0_last, (k % 16) == 15);
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("d0_done", d0_done, 1);
        chk("d0_beats", k, 32);
        chk("d0_gap_end", gap, 0);
        @(negedge clk);
        chk("d0_done_end", d0_done, 0);
        chk("d0_busy_end", d0_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_stream_generator.md
MATRIX_STREAM_GENERATOR -- requirements
Module: matrix_stream_generator

Interface
REQ-001 Parameter DATA_W, default 32: stream data width in bits, legal range 8..64.
REQ-002 Parameter ROWS, default 4: rows per matrix, legal range 1..256.
REQ-003 Parameter COLS, default 4: columns per matrix, legal range 1..256.
REQ-004 Parameter NUM_MATRICES, default 2: matrices emitted per start, legal range 1..16.
REQ-005 Parameter GAP_CYCLES, default 20000: idle cycles before each matrix, legal range 0..2^20-1.
REQ-006 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port start, input, 1: single-cycle request to begin a run.
REQ-009 Port mode, input, 2: pattern select (0 increment, 1 identity, 2 constant, 3 LFSR).
REQ-010 Port seed, input, DATA_W: base value for modes 0, 2 and 3.
REQ-011 Port input_r_TDATA_0, output, DATA_W: AXI-Stream data.
REQ-012 Port input_r_TVALID_0, output, 1: AXI-Stream valid.
REQ-013 Port input_r_TLAST_0, output, 1: high on the last element of each matrix.
REQ-014 Port input_r_TREADY_0, input, 1: AXI-Stream ready from the consumer.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: one-cycle pulse when a run completes.

Function
REQ-017 The FSM SHALL have states IDLE, GAP, STREAM and DONE.
REQ-018 IDLE SHALL go to GAP on start=1, latching mode and seed, clearing the gap counter, and setting matrix index m=0, row r=0, col c=0.
REQ-019 start SHALL be ignored in every state except IDLE.
REQ-020 GAP SHALL hold TVALID=0 for exactly GAP_CYCLES cycles, then enter STREAM; if GAP_CYCLES=0, GAP SHALL last one cycle.
REQ-021 In STREAM, TVALID SHALL be 1; a beat transfers on a cycle where TVALID=1 and TREADY=1.
REQ-022 While TVALID=1 and TREADY=0, TDATA and TLAST SHALL hold their values.
REQ-023 Element order SHALL be row-major; c increments per beat, wraps at COLS-1 and increments r.
REQ-024 TLAST SHALL be 1 only when r=ROWS-1 and c=COLS-1.
REQ-025 After a TLAST beat transfers, the FSM SHALL go to GAP if m<NUM_MATRICES-1 (incrementing m and clearing r and c), else to DONE.
REQ-026 Mode 0 SHALL output (seed + m*ROWS*COLS + r*COLS + c) mod 2^DATA_W.
REQ-027 Mode 1 SHALL output 1 when r=c, else 0.
REQ-028 Mode 2 SHALL output seed on every beat.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-030 Outputs SHALL be registered; the first STREAM beat SHALL be valid on the cycle after GAP ends.

Reset
REQ-031 Asserting reset at any time, including mid-beat while TREADY=0, SHALL immediately force state IDLE and set TVALID=0, TLAST=0, TDATA=0, busy=0, done=0, and all counters and the LFSR state to 0.
REQ-032 After reset deasserts, the block SHALL remain in IDLE until start=1.

Configuration
REQ-033 With macro MATGEN_LFSR_EN defined, mode 3 SHALL output a DATA_W-bit Galois LFSR loaded with seed at start (seed=0 replaced by 1), advanced once per transferred beat and held while TREADY=0.
REQ-034 Without MATGEN_LFSR_EN, mode 3 SHALL behave as mode 0 and no LFSR logic SHALL be synthesised.

Verification
REQ-035 Defaults, mode=0, seed=0, TREADY=1, one start pulse -> 20000 idle cycles, beats 0..15 with TLAST on 15, 20000 idle cycles, beats 16..31 with TLAST on 31, then done=1 for one cycle.
REQ-036 ROWS=3, COLS=3, mode=1, GAP_CYCLES=0, NUM_MATRICES=1 -> output 1,0,0,0,1,0,0,0,1 with TLAST on the 9th beat.
REQ-037 mode=0, seed=5, TREADY held low for 10 cycles mid-stream -> TDATA frozen at 5+k during the stall, with no beat lost or duplicated.
REQ-038 DATA_W=8, mode=0, seed=250 -> sequence 250..255,0,1,... (wrap mod 256).
REQ-039 reset pulse during STREAM with TREADY=0 -> TVALID=0 and busy=0 immediately; a following start produces a fresh run from m=0.
REQ-040 MATGEN_LFSR_EN defined, mode=3, seed=0 -> first beat is 1, subsequent beats follow the LFSR polynomial; a second start pulse issued while busy has no effect.
